// File: rtl/cv32e40p_pkg.sv
// Shared types and defaults for the TMR fault monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cv32e40p_pkg;

  // Health classification of the TMR interrupt controller; 2'b11 is illegal.
  typedef enum logic [1:0] {
    FM_OK        = 2'b00,
    FM_TRANSIENT = 2'b01,
    FM_PERMANENT = 2'b10
  } tmr_fm_state_e;

  // Default configuration: one flag per voter (req, sec, id, wu, mip).
  localparam int unsigned FM_NUM_SRC        = 5;
  localparam int unsigned FM_CNT_W          = 8;
  localparam int unsigned FM_PERSIST_CYCLES = 4;

  // Width needed to hold a run length of 0..persist inclusive.
  function automatic int unsigned fm_run_width(input int unsigned persist);
    return $clog2(persist + 1);
  endfunction

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Up-counter that saturates at MAX and clears synchronously on clr_i.
// Latency: 1 cycle from inc_i/clr_i to cnt_o; clr_i has priority over inc_i.
// Backpressure: none; increments at MAX are silently dropped.
module cv32e40p_sat_counter #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// Records, counts and classifies TMR voter mismatches; clears via req/ack handshake.
// Latency: 1 cycle from fault_i/clr_req_i to every output (all outputs registered).
// Backpressure: clr_req_i is held pending while any voter mismatches; no backpressure on fault_i.
module cv32e40p_tmr_fault_monitor
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NUM_SRC        = FM_NUM_SRC,
  parameter int unsigned CNT_W          = FM_CNT_W,
  parameter int unsigned PERSIST_CYCLES = FM_PERSIST_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] fault_i,
  input  logic               clr_req_i,
  output logic               clr_ack_o,
  output logic [NUM_SRC-1:0] fault_sticky_o,
  output logic [CNT_W-1:0]   fault_cnt_o,
  output tmr_fm_state_e      state_o,
  output logic               alarm_o,
  output logic               permanent_o
);

  localparam int unsigned       RUN_W    = fm_run_width(PERSIST_CYCLES);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(PERSIST_CYCLES);
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(PERSIST_CYCLES - 1);

  logic               any_fault;
  logic               any_fault_q;
  logic               fault_event;
  logic               clr_accept;
  logic [RUN_W-1:0]   run_q;

  logic               clr_ack_q, clr_ack_d;
  logic [NUM_SRC-1:0] sticky_q, sticky_d;
  tmr_fm_state_e      state_q, state_d;
  logic               alarm_q, perm_q;

  assign any_fault   = |fault_i;
  assign fault_event = any_fault & ~any_fault_q;
  // The ack cycle itself is excluded so a held request produces one ack per handshake.
  assign clr_accept  = clr_req_i & ~any_fault & ~clr_ack_q;

  // Edge detector history for the fault-event definition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_fault_q <= 1'b0;
    end else begin
      any_fault_q <= any_fault;
    end
  end

  cv32e40p_sat_counter #(
    .WIDTH (CNT_W)
  ) u_event_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (fault_event),
    .clr_i (1'b0),
    .cnt_o (fault_cnt_o)
  );

  // Run length of consecutive faulty cycles; any clean cycle restarts it.
  cv32e40p_sat_counter #(
    .WIDTH (RUN_W),
    .MAX   (RUN_MAX)
  ) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (any_fault),
    .clr_i (~any_fault),
    .cnt_o (run_q)
  );

  // Classification next state; the illegal encoding falls back to the safe PERMANENT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FM_OK: begin
        if (any_fault) begin
          state_d = FM_TRANSIENT;
        end
      end
      FM_TRANSIENT: begin
        if (any_fault && (run_q == RUN_LAST)) begin
          state_d = FM_PERMANENT;
        end else if (clr_accept) begin
          state_d = FM_OK;
        end
      end
      FM_PERMANENT: begin
        if (clr_accept) begin
          state_d = FM_OK;
        end
      end
      default: begin
        state_d = FM_PERMANENT;
      end
    endcase
  end

  // Sticky capture and acknowledge generation.
  always_comb begin
    clr_ack_d = clr_accept;
    sticky_d  = sticky_q | fault_i;
    if (clr_accept) begin
      sticky_d = '0;
    end
  end

  // Output registers; alarm/permanent are decoded from the next state so they align with state_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FM_OK;
      clr_ack_q <= 1'b0;
      sticky_q  <= '0;
      alarm_q   <= 1'b0;
      perm_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ack_q <= clr_ack_d;
      sticky_q  <= sticky_d;
      alarm_q   <= (state_d != FM_OK);
      perm_q    <= (state_d == FM_PERMANENT);
    end
  end

  assign state_o        = state_q;
  assign clr_ack_o      = clr_ack_q;
  assign fault_sticky_o = sticky_q;
  assign alarm_o        = alarm_q;
  assign permanent_o    = perm_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
module tb_cv32e40p_tmr_fault_monitor;
  import cv32e40p_pkg::*;

  localparam int NS = 5;
  localparam int CW = 8;
  localparam int PC = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] fault_i = '0;
  logic          clr_req_i = 1'b0;
  logic          clr_ack_o;
  logic [NS-1:0] fault_sticky_o;
  logic [CW-1:0] fault_cnt_o;
  tmr_fm_state_e state_o;
  logic          alarm_o;
  logic          permanent_o;

  int errors = 0;
  int checks = 0;

  cv32e40p_tmr_fault_monitor #(
    .NUM_SRC        (NS),
    .CNT_W          (CW),
    .PERSIST_CYCLES (PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fault_i        (fault_i),
    .clr_req_i      (clr_req_i),
    .clr_ack_o      (clr_ack_o),
    .fault_sticky_o (fault_sticky_o),
    .fault_cnt_o    (fault_cnt_o),
    .state_o        (state_o),
    .alarm_o        (alarm_o),
    .permanent_o    (permanent_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state named as 0=OK, 1=TRANSIENT, 2=PERMANENT; run length kept unbounded.
  int            m_cnt, m_run, m_state;
  logic [NS-1:0] m_sticky;
  bit            m_prev, m_ack;

  always @(posedge clk or posedge rst) begin
    bit any, acc;
    if (rst) begin
      m_cnt = 0; m_run = 0; m_state = 0; m_sticky = '0; m_prev = 0; m_ack = 0;
    end else begin
      any = (fault_i != '0);
      acc = clr_req_i && !any && !m_ack;
      if (any && !m_prev && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_sticky = acc ? '0 : (m_sticky | fault_i);
      m_run = any ? m_run + 1 : 0;
      if (m_run > 1000) m_run = 1000;
      if (acc) m_state = 0;
      else if (any) begin
        if (m_run >= PC) m_state = 2;
        else if (m_state == 0) m_state = 1;
      end
      m_ack = acc;
      m_prev = any;
    end
  end

  // Continuous comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("cyc.ack",    32'(clr_ack_o),      32'(m_ack));
      check("cyc.sticky", 32'(fault_sticky_o), 32'(m_sticky));
      check("cyc.cnt",    32'(fault_cnt_o),    32'(m_cnt));
      check("cyc.state",  32'(state_o),        32'(m_state));
      check("cyc.alarm",  32'(alarm_o),        32'(m_state != 0));
      check("cyc.perm",   32'(permanent_o),    32'(m_state == 2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int ack, input int sticky, input int cnt,
                            input int st, input int alarm, input int perm);
    check({tag, ".ack"},    32'(clr_ack_o),      32'(ack));
    check({tag, ".sticky"}, 32'(fault_sticky_o), 32'(sticky));
    check({tag, ".cnt"},    32'(fault_cnt_o),    32'(cnt));
    check({tag, ".state"},  32'(state_o),        32'(st));
    check({tag, ".alarm"},  32'(alarm_o),        32'(alarm));
    check({tag, ".perm"},   32'(permanent_o),    32'(perm));
  endtask

  task automatic do_clear(input string tag, input int cnt);
    fault_i = '0;
    clr_req_i = 1'b1;
    step();
    expect_out({tag, ".ack"}, 1, 0, cnt, 0, 0, 0);
    clr_req_i = 1'b0;
    step();
    check({tag, ".ackdrop"}, 32'(clr_ack_o), 32'(0));
  endtask

  initial begin
    int burst;
    logic [NS-1:0] pat;
    burst = 0;
    pat = '0;

    // Reset state, asynchronous and held across edges.
    #1;
    expect_out("rst0", 0, 0, 0, 0, 0, 0);
    step(); step();
    expect_out("rst1", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // Single glitch on the ID voter, then clear.
    fault_i = 5'b00100;
    step();
    expect_out("glitch", 0, 5'b00100, 1, 1, 1, 0);
    do_clear("glitch_clr", 1);

    // Clear then fault on the very next cycle.
    clr_req_i = 1'b1;
    step();
    check("rearm.ack", 32'(clr_ack_o), 32'(1));
    clr_req_i = 1'b0;
    fault_i = 5'b00010;
    step();
    expect_out("rearm", 0, 5'b00010, 2, 1, 1, 0);
    do_clear("rearm_clr", 2);

    // Three faulty cycles stay transient; then async reset mid-cycle.
    fault_i = 5'b10000;
    step(); step(); step();
    fault_i = '0;
    step();
    expect_out("run3", 0, 5'b10000, 3, 1, 1, 0);
    #2 rst = 1'b1;
    #1;
    expect_out("midrst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // Four faulty cycles become permanent.
    fault_i = 5'b10000;
    step(); step(); step();
    expect_out("run3b", 0, 5'b10000, 1, 1, 1, 0);
    step();
    expect_out("perm", 0, 5'b10000, 1, 2, 1, 1);
    fault_i = '0;
    step();
    check("perm.hold", 32'(state_o), 32'(2));
    do_clear("perm_clr", 1);

    // Clear held off while the request voter mismatches.
    fault_i = 5'b00001;
    clr_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("blocked.ack", 32'(clr_ack_o), 32'(0));
    end
    fault_i = '0;
    step();
    expect_out("unblocked", 1, 0, 2, 0, 0, 0);
    clr_req_i = 1'b0;
    step();

    // Saturation of the event counter.
    for (int i = 0; i < 300; i++) begin
      fault_i = 5'b01000;
      step();
      fault_i = '0;
      step();
    end
    check("sat.cnt", 32'(fault_cnt_o), 32'(CNT_MAX));
    do_clear("sat_clr", CNT_MAX);

    // Randomized traffic with a well-behaved requester.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    for (int c = 0; c < 3000; c++) begin
      if (burst == 0) begin
        if ($urandom_range(0, 4) == 0) begin
          burst = $urandom_range(1, 7);
          pat = NS'($urandom_range(1, (1 << NS) - 1));
        end
      end
      if (burst > 0) begin
        fault_i = pat;
        burst--;
        if ($urandom_range(0, 3) == 0) pat = NS'($urandom_range(1, (1 << NS) - 1));
      end else begin
        fault_i = '0;
      end
      if (clr_req_i && clr_ack_o) begin
        clr_req_i = ($urandom_range(0, 7) == 0);
      end else if (!clr_req_i) begin
        clr_req_i = ($urandom_range(0, 7) == 0);
      end
      step();
    end
    fault_i = '0;
    clr_req_i = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_fault_monitor.md
# cv32e40p_tmr_fault_monitor

Downstream consumer of the per-voter mismatch flags of the TMR interrupt controller (request, secure, ID, wake-up and MIP voters). The monitor:
- records which voters disagreed;
- counts fault events;
- classifies the module as fault-free, transiently faulted or permanently faulted;
- lets software or the controller acknowledge and clear transient faults through a request/acknowledge handshake.

## Interface
- NUM_SRC, 5, number of voter `detected` flags monitored (bit 0 req, 1 sec, 2 id, 3 wu, 4 mip)
- CNT_W, 8, width of the saturating fault-event counter
- PERSIST_CYCLES, 4, consecutive faulty cycles that classify a fault as permanent; legal range ≥ 2
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- fault_i  in  NUM_SRC  voter mismatch flags, one per voter, sampled every cycle
- clr_req_i  in  1  clear request; held high until acknowledged
- clr_ack_o  out  1  one-cycle acknowledge of an accepted clear
- fault_sticky_o  out  NUM_SRC  per-source sticky flag; set on any cycle that source is high
- fault_cnt_o  out  CNT_W  saturating count of fault events
- state_o  out  2  classification, of type tmr_fm_state_e
- alarm_o  out  1  high when state_o ≠ FM_OK
- permanent_o  out  1  high when state_o = FM_PERMANENT

## Operation
- any_fault = OR of fault_i. A fault event is a rising edge of any_fault, i.e. any_fault & ~any_fault_q, where any_fault_q is the registered any_fault.
- fault_cnt_o increments by 1 per event and saturates at 2^CNT_W−1. It is not cleared by a clear; only rst clears it.
- fault_sticky_o[i] is set whenever fault_i[i]=1. All sticky bits are cleared on an accepted clear.
- run_q counts consecutive cycles with any_fault=1, width $clog2(PERSIST_CYCLES+1).
  - It returns to 0 on any cycle with any_fault=0.
  - It saturates at PERSIST_CYCLES.
- FSM states and transitions:
  - FM_OK → FM_TRANSIENT when any_fault=1.
  - FM_TRANSIENT → FM_PERMANENT when any_fault=1 and run_q = PERSIST_CYCLES−1.
  - FM_TRANSIENT → FM_OK on an accepted clear.
  - FM_PERMANENT → FM_OK on an accepted clear.
  - Otherwise the FSM holds its state.
- Clear acceptance:
  - A clear is accepted when clr_req_i=1, any_fault=0 and clr_ack_o=0 in that cycle.
  - While any_fault=1 the request stays pending and is not acknowledged. A fault on the same cycle as the request wins.
  - A clear requested in FM_OK is still acknowledged and clears the sticky bits; the state stays FM_OK.
- The requester drops clr_req_i the cycle after it sees clr_ack_o. If the request is still high the cycle after an ack, it starts a new handshake.

## Timing
- Every output is registered, with zero combinational path from any input.
- Reset values: clr_ack_o=0, fault_sticky_o=0, fault_cnt_o=0, state_o=FM_OK, alarm_o=0, permanent_o=0; internal run_q=0 and any_fault_q=0.
- Reset asserted mid-operation, including during a pending clear, returns all of the above immediately, without waiting for a clock edge.
- Fault-to-flag latency: fault_i high before edge N gives sticky, count, state and alarm updated after edge N (1 cycle).
- Permanent classification: any_fault high before edges N … N+PERSIST_CYCLES−1 gives permanent_o high after edge N+PERSIST_CYCLES−1.
- Clear latency: clear accepted before edge N gives clr_ack_o high for exactly the cycle after edge N, with state and sticky bits cleared at that same edge.
- A fault on the cycle directly after an accepted clear re-enters FM_TRANSIENT after the next edge and counts as a new event.
- The counter at saturation ignores further events, and no wrap-around occurs.

## Structure
- The typedef tmr_fm_state_e (2-bit enum: FM_OK=2'b00, FM_TRANSIENT=2'b01, FM_PERMANENT=2'b10) goes in cv32e40p_pkg. The encoding 2'b11 is illegal; the FSM recovers from it to FM_PERMANENT.
- Sub-module cv32e40p_sat_counter #(WIDTH) with ports clk, rst, inc_i, clr_i, cnt_o. It is used for fault_cnt_o; run_q uses its clr_i for the reset-on-no-fault.
- The FSM, the sticky register and the clear handshake live in the top module.

## Test plan
- **Reset:** pulse rst mid-count with fault_cnt_o=3 and state FM_TRANSIENT → all outputs reset immediately, with no clock edge needed.
- **Single glitch:** fault_i=5'b00100 for 1 cycle → after the edge: state FM_TRANSIENT, alarm_o=1, fault_sticky_o=5'b00100, fault_cnt_o=1, permanent_o=0. Then clr_req_i=1 → clr_ack_o pulses 1 cycle, state FM_OK, sticky bits 0, count stays 1.
- **Persistence:** fault_i=5'b10000 held for 4 cycles → permanent_o=1 after the 4th edge. Held for 3 cycles then 0 → stays FM_TRANSIENT.
- **Clear blocked:** clr_req_i=1 while fault_i=5'b00001 for 3 cycles → no ack during those cycles. The ack arrives 1 cycle after fault_i drops.
- **Saturation:** with CNT_W=8, apply 300 separate 1-cycle glitches → fault_cnt_o=255, with no wrap.
- **Re-arm:** fault_i high on the cycle right after an accepted clear → FM_TRANSIENT again and fault_cnt_o incremented by 1.
